// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults, index-width helper and search-result type for the CAM.
package cam_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int MAX_IDX_W = 16;
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  typedef struct packed {
    logic valid;
    logic multi;
    logic [MAX_IDX_W-1:0] index;
  } search_res_t;
endpackage

// File: rtl/cam_priority_enc.sv
// cam_priority_enc: lowest-index priority encoder with any-hit and multi-hit flags.
module cam_priority_enc import cam_pkg::*; #(
  parameter int N = DEFAULT_DEPTH,
  localparam int IW = clog2_safe(N)
) (
  input  logic [N-1:0]  match_i,
  output logic [IW-1:0] index_o,
  output logic          valid_o,
  output logic          multi_o
);
  always_comb begin
    index_o = '0;
    valid_o = 1'b0;
    multi_o = 1'b0;
    for (int i = 0; i < N; i++)
      if (match_i[i]) begin
        if (!valid_o) index_o = IW'(i);
        multi_o = multi_o | valid_o;
        valid_o = 1'b1;
      end
  end
endmodule

// File: rtl/param_cam.sv
// param_cam: masked CAM with registered read port, invalidate/flush and a 2-stage search pipeline.
module param_cam import cam_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int IDX_W = clog2_safe(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_enable_i,
  input  logic [IDX_W-1:0]      write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  invalidate_i,
  input  logic [IDX_W-1:0]      inval_index_i,
  input  logic                  flush_i,
  input  logic                  read_enable_i,
  input  logic [IDX_W-1:0]      read_index_i,
  output logic [DATA_WIDTH-1:0] read_value_o,
  output logic                  read_valid_o,
  input  logic                  search_enable_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  input  logic [DATA_WIDTH-1:0] search_mask_i,
  output logic                  search_done_o,
  output logic                  search_valid_o,
  output logic [IDX_W-1:0]      search_index_o,
  output logic                  search_multi_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, match_q, match_d;
  logic s1_v_q, done_q, read_valid_q, res_valid_q, res_multi_q;
  logic [DATA_WIDTH-1:0] read_value_q;
  logic [IDX_W-1:0] res_index_q, enc_index;
  logic enc_valid, enc_multi;
  // flush first, then invalidate, then write: a write always wins on its own index
  always_comb begin
    valid_d = flush_i ? '0 : valid_q;
    if (invalidate_i) valid_d[inval_index_i] = 1'b0;
    if (write_enable_i) valid_d[write_index_i] = 1'b1;
  end
  always_comb begin
    match_d = '0;
    for (int i = 0; i < DEPTH; i++)
      match_d[i] = valid_q[i] && (((mem_q[i] ^ search_data_i) & search_mask_i) == '0);
  end
  cam_priority_enc #(.N(DEPTH)) u_enc (
    .match_i(match_q),
    .index_o(enc_index),
    .valid_o(enc_valid),
    .multi_o(enc_multi)
  );
  always_ff @(posedge clk_i)
    if (write_enable_i) mem_q[write_index_i] <= write_data_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      match_q      <= '0;
      s1_v_q       <= 1'b0;
      done_q       <= 1'b0;
      read_valid_q <= 1'b0;
      read_value_q <= '0;
      res_valid_q  <= 1'b0;
      res_multi_q  <= 1'b0;
      res_index_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      match_q      <= match_d;
      s1_v_q       <= search_enable_i;
      done_q       <= s1_v_q;
      read_valid_q <= read_enable_i && valid_q[read_index_i];
      if (read_enable_i) read_value_q <= mem_q[read_index_i];
      if (s1_v_q) begin
        res_valid_q <= enc_valid;
        res_multi_q <= enc_multi;
        res_index_q <= enc_index;
      end
    end
  end
  assign read_value_o   = read_value_q;
  assign read_valid_o   = read_valid_q;
  assign search_done_o  = done_q;
  assign search_valid_o = res_valid_q;
  assign search_index_o = res_index_q;
  assign search_multi_o = res_multi_q;
endmodule

// File: doc/param_cam.md
Name: param_cam

Overview:
- Parametrised content-addressable memory: DEPTH entries of DATA_WIDTH bits, each with a valid bit.
- Adds a per-search don't-care mask, a registered read port, single-entry invalidate and global flush.
- Search is a 2-stage pipeline: a compare stage, then a lowest-index priority encode stage.
- Drop-in successor for the fixed 32x32 CAM in the lookup path.

Parameters:
DATA_WIDTH, 32, bits per entry
DEPTH, 32, number of entries; power of two, >= 2
IDX_W, $clog2(DEPTH), index width; derived, not overridden

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
write_enable_i  in  1  write write_data_i into entry write_index_i and set its valid bit
write_index_i  in  IDX_W  write target
write_data_i  in  DATA_WIDTH  write data
invalidate_i  in  1  clear valid bit of entry inval_index_i
inval_index_i  in  IDX_W  invalidate target
flush_i  in  1  clear all valid bits
read_enable_i  in  1  read request
read_index_i  in  IDX_W  read address
read_value_o  out  DATA_WIDTH  registered read data
read_valid_o  out  1  registered: request accepted and entry valid
search_enable_i  in  1  launch a search
search_data_i  in  DATA_WIDTH  search key
search_mask_i  in  DATA_WIDTH  1 = compare this bit, 0 = don't care
search_done_o  out  1  result strobe, 2 cycles after launch
search_valid_o  out  1  at least one match (qualified by search_done_o)
search_index_o  out  IDX_W  lowest matching index
search_multi_o  out  1  more than one entry matched

Behaviour:
- Reset (async, rst_i=1): all valid bits 0, all outputs 0, pipeline valid flags 0. Entry data is not reset.
- Storage updates on the rising edge. All reads and searches in cycle N see the array state from before edge N.
- Write: entry[wi] <= write_data_i; valid[wi] <= 1.
- Priority at the same edge: flush_i clears every valid bit, then a write sets its own entry's bit.
  - Write beats invalidate on the same index.
  - Invalidate and write on different indices both take effect.
- Read: latency 1.
  - read_value_o <= entry[read_index_i]; read_valid_o <= read_enable_i & valid[read_index_i].
  - read_value_o holds its value when read_enable_i=0. read_valid_o is 0 in that cycle.
- Search stage 1, at the launch edge: match_r[i] <= valid[i] & (((entry[i] ^ search_data_i) & search_mask_i) == 0). s1_v <= search_enable_i.
- Search stage 2, at the next edge:
  - search_done_o <= s1_v; search_valid_o <= |match_r.
  - search_index_o <= lowest i with match_r[i], else 0.
  - search_multi_o <= popcount(match_r) > 1.
- Total search latency is 2. A new search may launch every cycle (fully pipelined, no stall).
- Search results are registered: they update only when s1_v=1 and otherwise hold. search_done_o is a single-cycle strobe.
- An all-zero mask matches every valid entry.
- A search launched in the same cycle as a write to a matching entry misses it. A search launched in the next cycle hits it.
- A flush on the launch edge does not affect a search already in stage 2.
- Reset mid-search: in-flight results are discarded and search_done_o is not asserted afterwards.
- Index inputs are always in range, because DEPTH is a power of two.

Decomposition:
- cam_pkg holds:
  - localparams DEFAULT_DATA_WIDTH=32 and DEFAULT_DEPTH=32.
  - A function clog2_safe.
  - A typedef for the search-result struct {valid, multi, index}, parametrised through a class-free packed width convention.
- One sub-module: cam_priority_enc.
  - Parameter N.
  - Input: match vector.
  - Outputs: index, valid, multi.
  - Purely combinational; the parent registers its outputs.
- Storage stays a 2-D reg array in param_cam. There is no per-row instance.

Test Plan:
- Reset, then write entry 3 = 0xDEADBEEF, then read index 3 -> next cycle read_value_o=0xDEADBEEF, read_valid_o=1. Reading index 4 -> read_valid_o=0.
- Write entries 5 and 9 = 0x000000AA. Search 0xAA with mask 0xFFFFFFFF -> 2 cycles later done=1, valid=1, index=5, multi=1.
- Ternary search: entry 7=0x12345678, search 0x12340000 with mask 0xFFFF0000 -> index=7, valid=1. The same search with mask 0xFFFFFFFF -> valid=0.
- Same-cycle hazard: write entry 2=0x55 and search 0x55 in cycle N -> miss. Search again in N+1 -> hit at index 2. Back-to-back searches give a done strobe on consecutive cycles.
- Invalidate entry 5 after the scenario 2 setup, then search 0xAA -> index=9, multi=0. Then flush_i, then search -> valid=0. Write and invalidate the same index in the same cycle -> entry remains valid.
- Assert rst_i one cycle after a search launch -> search_done_o stays 0, all valid bits are cleared, and a later search returns valid=0.
